// File: rtl/pdm_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// deserializer_pkg
//   Shared types and helpers for the PDM / serial-ADC deserializer.
//   - deserializer_state_t : capture FSM states
//   - divide()             : system-to-serial clock divisor
// ---------------------------------------------------------------------------
package deserializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } deserializer_state_t;

   // Number of system clock cycles per serial bit.
   function automatic int divide(input int system, input int sampling);
      return system / sampling;
   endfunction

endpackage

// File: rtl/pdm_deserializer_sample_clock_generator.sv
// ---------------------------------------------------------------------------
// sample_clock_generator
//   Divides clock_i down to the serial device clock and marks the system
//   cycle on which the serial bit is to be captured.
//   Ports:
//     clock_i        system clock
//     reset_i        synchronous, active-high reset
//     run_i          1 = count, 0 = hold the divider cleared at zero
//     serial_clock_o device clock, low for the first DIVIDE/2 counts
//     tick_o         high in the last count of a serial period (capture edge
//                    coincides with the falling edge of serial_clock_o)
// ---------------------------------------------------------------------------
module sample_clock_generator #(
   parameter int DIVIDE = 8
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic run_i,
   output logic serial_clock_o,
   output logic tick_o
);

   localparam int CW = $clog2(DIVIDE);
   localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);
   localparam logic [CW-1:0] HALF = CW'(DIVIDE / 2);

   logic [CW-1:0] div_count;
   logic [CW-1:0] div_next;

   always_comb begin
      div_next = '0;
      if (run_i && (div_count != LAST)) begin
         div_next = div_count + 1'b1;
      end
   end

   // The device clock is registered from the next count so it never
   // glitches and always equals (div_count >= DIVIDE/2).
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         div_count      <= '0;
         serial_clock_o <= 1'b0;
      end else begin
         div_count      <= div_next;
         serial_clock_o <= (div_next >= HALF);
      end
   end

   assign tick_o = run_i && (div_count == LAST);

endmodule

// File: rtl/pdm_deserializer.sv
// ---------------------------------------------------------------------------
// pdm_deserializer
//   Collects a 1-bit serial stream into WORD_LENGTH-bit words, MSB first,
//   and generates the device clock it is sampled with.
//   Ports:
//     clock_i             system clock
//     reset_i             synchronous, active-high reset
//     enable_i            high = capture; low = stop, drop partial word
//     serial_data_i       serial bit, launched by the device on serial_clock_o
//     serial_clock_o      device clock at SAMPLING_FREQUENCY, 50 % duty
//     data_o              last completed word (MSB = first bit received)
//     deserializer_done_o one-cycle pulse when data_o is newly valid
//     busy_o              high while capturing
// ---------------------------------------------------------------------------
module pdm_deserializer
   import deserializer_pkg::*;
#(
   parameter int WORD_LENGTH        = 16,
   parameter int SYSTEM_FREQUENCY   = 100000000,
   parameter int SAMPLING_FREQUENCY = 1000000
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   enable_i,
   input  logic                   serial_data_i,
   output logic                   serial_clock_o,
   output logic [WORD_LENGTH-1:0] data_o,
   output logic                   deserializer_done_o,
   output logic                   busy_o
);

   localparam int DIVIDE = divide(SYSTEM_FREQUENCY, SAMPLING_FREQUENCY);
   localparam int BW     = $clog2(WORD_LENGTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WORD_LENGTH - 1);

   if (DIVIDE < 2) begin : g_chk_div_min
      $error("pdm_deserializer: DIVIDE must be >= 2");
   end
   if ((DIVIDE % 2) != 0) begin : g_chk_div_even
      $error("pdm_deserializer: DIVIDE must be even");
   end
   if (WORD_LENGTH < 1) begin : g_chk_word
      $error("pdm_deserializer: WORD_LENGTH must be >= 1");
   end

   deserializer_state_t state, state_next;
   logic                   run;
   logic                   tick;
   logic [BW-1:0]          bit_count;
   logic [WORD_LENGTH-1:0] shift_reg;
   logic [WORD_LENGTH-1:0] shift_next;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // run is only asserted while staying in SHIFT: the edge that samples
   // enable_i low must neither count, nor tick, nor raise done, and the
   // edge that enters SHIFT must leave the divider at zero.
   always_comb begin
      state_next = state;
      run        = 1'b0;
      case (state)
         IDLE: begin
            if (enable_i) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (!enable_i) begin
               state_next = IDLE;
            end else begin
               run = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy_o = (state == SHIFT);

   // ------------------------------------------------------ serial clock
   sample_clock_generator #(
      .DIVIDE (DIVIDE)
   ) u_sample_clock_generator (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
      .run_i          (run),
      .serial_clock_o (serial_clock_o),
      .tick_o         (tick)
   );

   // ---------------------------------------------------------- datapath
   if (WORD_LENGTH == 1) begin : g_shift_one
      assign shift_next = serial_data_i;
   end else begin : g_shift_many
      assign shift_next = {shift_reg[WORD_LENGTH-2:0], serial_data_i};
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         shift_reg           <= '0;
         data_o              <= '0;
         bit_count           <= '0;
         deserializer_done_o <= 1'b0;
      end else begin
         deserializer_done_o <= 1'b0;
         if (!run) begin
            // Partial word is dropped; stale shift_reg bits are flushed out
            // by the next full word before they can reach data_o.
            bit_count <= '0;
         end else if (tick) begin
            shift_reg <= shift_next;
            if (bit_count == LAST_BIT) begin
               data_o              <= shift_next;
               deserializer_done_o <= 1'b1;
               bit_count           <= '0;
            end else begin
               bit_count <= bit_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pdm_deserializer.sv
module tb_pdm_deserializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       sdata;
   logic       sclk;
   logic [3:0] data;
   logic       done;
   logic       busy;

   int         total = 0;
   int         bad   = 0;
   logic [3:0] model_data;

   typedef struct {
      logic [3:0] bits;
      logic [3:0] exp;
      string      name;
   } vec_t;

   vec_t tbl[4];

   pdm_deserializer #(
      .WORD_LENGTH        (4),
      .SYSTEM_FREQUENCY   (8),
      .SAMPLING_FREQUENCY (1)
   ) dut (
      .clock_i             (clk),
      .reset_i             (rst),
      .enable_i            (en),
      .serial_data_i       (sdata),
      .serial_clock_o      (sclk),
      .data_o              (data),
      .deserializer_done_o (done),
      .busy_o              (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Call at #1 after the edge that starts a word (E0 or the previous done
   // edge). Returns at #1 after the edge that should raise done.
   task automatic feed_word(input logic [3:0] w, input logic [3:0] exp, input string name);
      int spur;
      int sclk_bad;
      int hold_bad;
      spur = 0; sclk_bad = 0; hold_bad = 0;
      for (int b = 3; b >= 0; b--) begin
         sdata = w[b];
         for (int c = 0; c < 8; c++) begin
            step();
            if (b == 0 && c == 7) begin
               chk({name, "_done"}, 16'(done), 16'd1);
               chk({name, "_data"}, 16'(data), 16'(exp));
               model_data = exp;
            end else begin
               if (done !== 1'b0) spur++;
               if (data !== model_data) hold_bad++;
               // count after this edge is c+1; clock high for counts 4..7
               if (sclk !== ((c >= 3) && (c <= 6))) sclk_bad++;
            end
         end
      end
      chk({name, "_no_early_done"}, 16'(spur), 16'd0);
      chk({name, "_sclk_shape"}, 16'(sclk_bad), 16'd0);
      chk({name, "_data_hold"}, 16'(hold_bad), 16'd0);
   endtask

   initial begin
      int cnt;
      tbl[0] = '{bits: 4'b1011, exp: 4'hB, name: "w0"};
      tbl[1] = '{bits: 4'b0110, exp: 4'h6, name: "w1"};
      tbl[2] = '{bits: 4'b0000, exp: 4'h0, name: "w2"};
      tbl[3] = '{bits: 4'b0101, exp: 4'h5, name: "w3"};

      rst = 1'b1; en = 1'b0; sdata = 1'b0;
      model_data = 4'h0;
      step(); step();
      chk("rst_data", 16'(data), 16'h0);
      chk("rst_done", 16'(done), 16'h0);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_sclk", 16'(sclk), 16'h0);
      rst = 1'b0;
      step();

      // Basic word followed by gap-free streaming.
      en = 1'b1;
      step();                      // E0
      chk("busy_after_e0", 16'(busy), 16'd1);
      chk("sclk_after_e0", 16'(sclk), 16'd0);
      for (int i = 0; i < 4; i++) begin
         feed_word(tbl[i].bits, tbl[i].exp, tbl[i].name);
      end
      en = 1'b0;
      step();
      chk("stream_done_one_cycle", 16'(done), 16'd0);
      chk("stop_busy", 16'(busy), 16'd0);
      chk("stop_sclk", 16'(sclk), 16'd0);
      chk("stop_data", 16'(data), 16'h5);

      // Idle: nothing may move.
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (sclk !== 1'b0 || busy !== 1'b0 || done !== 1'b0) cnt++;
      end
      chk("idle_quiet", 16'(cnt), 16'd0);
      chk("idle_data", 16'(data), 16'h5);

      // Abort after 2 bits.
      en = 1'b1;
      step();                      // E0
      sdata = 1'b1;
      for (int i = 0; i < 8; i++) step();
      sdata = 1'b0;
      for (int i = 0; i < 11; i++) step();
      en = 1'b0;
      step();
      chk("abort_busy", 16'(busy), 16'd0);
      chk("abort_sclk", 16'(sclk), 16'd0);
      chk("abort_done", 16'(done), 16'd0);
      chk("abort_data", 16'(data), 16'h5);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done !== 1'b0) cnt++;
      end
      chk("abort_no_done", 16'(cnt), 16'd0);
      en = 1'b1;
      step();                      // E0
      feed_word(4'b1111, 4'hF, "reen");

      // Reset after 3 bits of the next word, enable kept high.
      sdata = 1'b1;
      for (int i = 0; i < 24; i++) step();
      rst = 1'b1;
      step();
      chk("midrst_data", 16'(data), 16'h0);
      chk("midrst_done", 16'(done), 16'h0);
      chk("midrst_busy", 16'(busy), 16'h0);
      chk("midrst_sclk", 16'(sclk), 16'h0);
      model_data = 4'h0;
      rst = 1'b0;
      step();                      // first edge after reset: E0
      feed_word(4'b1001, 4'h9, "postrst");

      // Enable dropped on the edge of the final tick.
      sdata = 1'b0;
      for (int i = 0; i < 8; i++) step();
      sdata = 1'b1;
      for (int i = 0; i < 8; i++) step();
      sdata = 1'b0;
      for (int i = 0; i < 8; i++) step();
      sdata = 1'b1;
      for (int i = 0; i < 7; i++) step();
      en = 1'b0;
      step();                      // would-be 4th tick
      chk("simul_done", 16'(done), 16'd0);
      chk("simul_data", 16'(data), 16'h9);
      chk("simul_busy", 16'(busy), 16'd0);
      step();
      chk("simul_done_late", 16'(done), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
